// File: rtl/dual_tone_synth.sv
// dual_tone_synth: two square-wave voices with exact modulo-accumulator
// dividers, mixed into signed 16-bit PCM with a one-cycle valid strobe.
module dual_tone_synth #(
  parameter int unsigned TICK_DIV  = 1042,
  parameter int unsigned SAMPLE_HZ = 48000,
  parameter int unsigned AMP       = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [10:0] freq1,
  input  logic [10:0] freq2,
  output logic [15:0] sample,
  output logic        sample_valid
);

  localparam int unsigned FW = 11;
  localparam int unsigned AW = 17;
  localparam int unsigned SW = 18;
  localparam int unsigned OW = 16;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned NV = 2;

  localparam logic [PW-1:0]        PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]        HZ_S     = SW'(SAMPLE_HZ);
  localparam logic signed [OW-1:0] AMP_P    = OW'(AMP);
  localparam logic signed [OW-1:0] AMP_N    = -AMP_P;

  logic [PW-1:0]        pre_q, pre_d;
  logic [AW-1:0]        acc_q [NV];
  logic [AW-1:0]        acc_d [NV];
  logic                 neg_q [NV];
  logic                 neg_d [NV];
  logic                 act_q [NV];
  logic                 act_d [NV];
  logic                 mix_q, mix_d;
  logic signed [OW-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;

  logic                 tick_c;
  logic [FW-1:0]        freq_c  [NV];
  logic [SW-1:0]        twof_c  [NV];
  logic [SW-1:0]        sum_c   [NV];
  logic signed [OW-1:0] level_c [NV];

  assign sample       = sample_q;
  assign sample_valid = valid_q;

  // Prescaler: free-runs while enabled, tick on the last count.
  always_comb begin
    pre_d  = pre_q;
    tick_c = en && (pre_q == PRE_LAST);
    if (en) begin
      if (tick_c) pre_d = '0;
      else        pre_d = pre_q + PW'(1);
    end
  end

  // Voice accumulators: advance by 2f per tick, toggle polarity on wrap.
  always_comb begin
    freq_c[0] = freq1;
    freq_c[1] = freq2;
    for (int v = 0; v < NV; v++) begin
      acc_d[v]  = acc_q[v];
      neg_d[v]  = neg_q[v];
      act_d[v]  = act_q[v];
      twof_c[v] = SW'({freq_c[v], 1'b0});
      sum_c[v]  = SW'(acc_q[v]) + twof_c[v];
      if (tick_c) begin
        if ((freq_c[v] == '0) || (twof_c[v] >= HZ_S)) begin
          acc_d[v] = '0;
          neg_d[v] = 1'b0;
          act_d[v] = 1'b0;
        end else begin
          act_d[v] = 1'b1;
          if (sum_c[v] >= HZ_S) begin
            acc_d[v] = AW'(sum_c[v] - HZ_S);
            neg_d[v] = ~neg_q[v];
          end else begin
            acc_d[v] = AW'(sum_c[v]);
          end
        end
      end
    end
  end

  // Per-voice square level from the registered voice state.
  always_comb begin
    for (int v = 0; v < NV; v++) begin
      level_c[v] = '0;
      if (act_q[v]) level_c[v] = neg_q[v] ? AMP_N : AMP_P;
    end
  end

  // Mix stage: one cycle after the tick, independent of en.
  always_comb begin
    mix_d    = tick_c;
    valid_d  = mix_q;
    sample_d = sample_q;
    if (mix_q) sample_d = level_c[0] + level_c[1];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q    <= '0;
      acc_q    <= '{default: '0};
      neg_q    <= '{default: 1'b0};
      act_q    <= '{default: 1'b0};
      mix_q    <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      act_q    <= act_d;
      mix_q    <= mix_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_dual_tone_synth.sv
// Bench for dual_tone_synth: two instances (48 kHz and 4 kHz moduli) share
// stimulus; a total-phase reference model feeds per-instance scoreboards.
module tb_dual_tone_synth;

  localparam int TD   = 4;
  localparam int HZ_A = 48000;
  localparam int HZ_B = 4000;
  localparam int AMP  = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [10:0] freq1 = '0;
  logic [10:0] freq2 = '0;
  logic [15:0] smp_a, smp_b;
  logic        vld_a, vld_b;

  dual_tone_synth #(.TICK_DIV(TD), .SAMPLE_HZ(HZ_A), .AMP(AMP)) dut_a (
    .clk(clk), .reset(reset), .en(en), .freq1(freq1), .freq2(freq2),
    .sample(smp_a), .sample_valid(vld_a));

  dual_tone_synth #(.TICK_DIV(TD), .SAMPLE_HZ(HZ_B), .AMP(AMP)) dut_b (
    .clk(clk), .reset(reset), .en(en), .freq1(freq1), .freq2(freq2),
    .sample(smp_b), .sample_valid(vld_b));

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   loga[$];
  int   logb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rst_cnt = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int logv(input int i, input int idx);
    if (i == 0) return (idx < loga.size()) ? loga[idx] : -99999;
    return (idx < logb.size()) ? logb[idx] : -99999;
  endfunction

  function automatic int logsz(input int i);
    return (i == 0) ? loga.size() : logb.size();
  endfunction

  // Reference model: each voice keeps its total phase advance; the wrap count
  // (total / modulus) gives the polarity, so f cycles per modulus ticks.
  initial begin : model
    int    pc;
    longint tot [2][2];
    bit    act [2][2];
    int    f [2];
    int    hz;
    exp_t  e;
    pc = 0;
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < 2; v++) begin
        tot[i][v] = 0;
        act[i][v] = 0;
      end
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        pc = 0;
        for (int i = 0; i < 2; i++)
          for (int v = 0; v < 2; v++) begin
            tot[i][v] = 0;
            act[i][v] = 0;
          end
        qa.delete();
        qb.delete();
        rst_cnt++;
      end else if (en) begin
        if (pc == TD - 1) begin
          pc = 0;
          f[0] = int'(freq1);
          f[1] = int'(freq2);
          for (int i = 0; i < 2; i++) begin
            hz = (i == 0) ? HZ_A : HZ_B;
            e.val = 0;
            for (int v = 0; v < 2; v++) begin
              if (f[v] == 0 || 2 * f[v] >= hz) begin
                tot[i][v] = 0;
                act[i][v] = 0;
              end else begin
                act[i][v] = 1;
                tot[i][v] += longint'(2 * f[v]);
              end
              if (act[i][v]) e.val += ((tot[i][v] / hz) % 2 == 0) ? AMP : -AMP;
            end
            e.cyc = cyc + 1;
            if (i == 0) qa.push_back(e);
            else        qb.push_back(e);
          end
        end else begin
          pc++;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT strobes, checks hold otherwise.
  initial begin : monitor
    int   cur [2];
    int   seen_rst;
    logic v;
    int   s;
    exp_t e;
    cur[0] = 0;
    cur[1] = 0;
    seen_rst = 0;
    forever begin
      @(negedge clk);
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        cur[0] = 0;
        cur[1] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        v = (i == 0) ? vld_a : vld_b;
        s = (i == 0) ? int'($signed(smp_a)) : int'($signed(smp_b));
        if (v) begin
          if (((i == 0) ? qa.size() : qb.size()) == 0) begin
            chk(i == 0 ? "unexpected_valid_a" : "unexpected_valid_b", 1, 0);
          end else begin
            e = (i == 0) ? qa.pop_front() : qb.pop_front();
            chk(i == 0 ? "valid_cycle_a" : "valid_cycle_b", cyc, e.cyc);
            chk(i == 0 ? "sample_a" : "sample_b", s, e.val);
            cur[i] = e.val;
            if (i == 0) loga.push_back(s);
            else        logb.push_back(s);
          end
        end else begin
          if (i == 0 && qa.size() > 0 && qa[0].cyc <= cyc) begin
            chk("missing_valid_a", 0, 1);
            void'(qa.pop_front());
          end
          if (i == 1 && qb.size() > 0 && qb[0].cyc <= cyc) begin
            chk("missing_valid_b", 0, 1);
            void'(qb.pop_front());
          end
          chk(i == 0 ? "hold_a" : "hold_b", s, cur[i]);
        end
      end
    end
  end

  task automatic wait_valid(input int i);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if ((i == 0) ? vld_a : vld_b) return;
      n++;
      if (n > 50) begin
        chk("wait_valid_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic wait_log(input int i, input int n);
    int budget;
    budget = 0;
    while (logsz(i) < n) begin
      @(negedge clk);
      #1;
      budget++;
      if (budget > 20000) begin
        chk("wait_log_timeout", 0, 1);
        return;
      end
    end
  endtask

  function automatic int sign_changes(input int i, input int st, input int n);
    int c;
    int prev;
    int x;
    c = 0;
    prev = logv(i, st);
    for (int k = 1; k < n; k++) begin
      x = logv(i, st + k);
      if ((x < 0) != (prev < 0)) c++;
      prev = x;
    end
    return c;
  endfunction

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    int cnt;
    int n;
    int held;
    reset = 1'b0;
    en    = 1'b1;
    freq1 = '0;
    freq2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sample_a", int'(smp_a), 0);
    chk("rst_valid_a", int'(vld_a), 0);
    chk("rst_sample_b", int'(smp_b), 0);
    chk("rst_valid_b", int'(vld_b), 0);
    reset = 1'b1;

    // First pulse two cycles after the first tick, then every TD cycles.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld_a && n < 50);
    chk("first_pulse_latency", n, TD + 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld_a && n < 50);
    chk("pulse_period", n, TD);
    #1;
    wait_log(0, logsz(0) + 8);

    // 440 Hz on voice 2: 54 positive samples then the first negative one.
    wait_valid(0);
    freq2 = 11'd440;
    st = logsz(0);
    wait_log(0, st + 2000);
    cnt = 0;
    for (int k = 0; k < 54; k++) if (logv(0, st + k) != AMP) cnt++;
    chk("first54_positive", cnt, 0);
    chk("sample55_negative", logv(0, st + 54), -AMP);
    chk("toggles_440", sign_changes(0, st, 2000), (880 * 2000) / HZ_A);

    // Stop and restart: silence, then a fresh accumulator.
    wait_valid(0);
    freq2 = 11'd0;
    st = logsz(0);
    wait_log(0, st + 1);
    chk("stop_zero", logv(0, st), 0);
    wait_valid(0);
    freq2 = 11'd440;
    st = logsz(0);
    wait_log(0, st + 56);
    chk("restart_first", logv(0, st), AMP);
    chk("restart_54", logv(0, st + 53), AMP);
    chk("restart_55", logv(0, st + 54), -AMP);

    // Both voices at 1000 Hz from a clean start.
    wait_valid(0);
    freq2 = 11'd0;
    wait_valid(0);
    wait_valid(0);
    freq1 = 11'd1000;
    freq2 = 11'd1000;
    st = logsz(0);
    wait_log(0, st + 500);
    cnt = 0;
    for (int k = 0; k < 500; k++)
      if (logv(0, st + k) != 2 * AMP && logv(0, st + k) != -2 * AMP) cnt++;
    chk("same_freq_magnitude", cnt, 0);
    chk("toggles_1000", sign_changes(0, st, 500), (2000 * 500) / HZ_A);

    // Enable gating for 100 cycles: no pulses, frozen sample and prescaler.
    wait_valid(0);
    en = 1'b0;
    held = int'(smp_a);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (vld_a) cnt++;
    end
    chk("gated_no_valid", cnt, 0);
    chk("gated_sample_frozen", int'(smp_a), held);
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld_a && n < 50);
    chk("resume_latency", n, TD);

    // Drop en the cycle after a tick: the pending pulse still appears.
    #1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (vld_a) cnt++;
    end
    chk("drop_after_tick_pulse", cnt, 1);
    en = 1'b1;

    // Randomized frequencies and enable activity.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: freq1 = 11'd0;
        1: freq1 = 11'($urandom_range(1, 60));
        default: freq1 = 11'($urandom_range(1, 2047));
      endcase
      case ($urandom_range(0, 3))
        0: freq2 = 11'd0;
        1: freq2 = 11'($urandom_range(1900, 2047));
        default: freq2 = 11'($urandom_range(1, 2047));
      endcase
      en = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    en = 1'b1;

    // Boundary on the 4 kHz instance: 2f equal to the modulus is silent.
    wait_valid(1);
    freq1 = 11'd2000;
    freq2 = 11'd0;
    st = logsz(1);
    wait_log(1, st + 6);
    cnt = 0;
    for (int k = 0; k < 6; k++) if (logv(1, st + k) != 0) cnt++;
    chk("boundary_silent", cnt, 0);

    // Reset mid-tone, then restart positive.
    freq1 = 11'd1000;
    wait_log(1, logsz(1) + 7);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_sample_b", int'(smp_b), 0);
    chk("midrst_valid_b", int'(vld_b), 0);
    chk("midrst_sample_a", int'(smp_a), 0);
    reset = 1'b1;
    #1;
    st = logsz(1);
    wait_log(1, st + 2);
    chk("after_reset_positive", logv(1, st), AMP);

    // Drain outstanding expectations.
    en = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_tone_synth.md
Name: dual_tone_synth

Overview:
- Consumes the two 11-bit note frequencies (Hz) from the note sequencer and produces a mixed two-voice square-wave audio stream.
- Output is signed 16-bit PCM at a fixed sample rate with a one-cycle valid strobe, for the audio codec serializer downstream.
- Each voice uses an exact fractional (modulo-accumulator) divider, so long-term tone frequency is exact. Pitch changes are taken only on sample ticks.

Parameters:
- TICK_DIV, 1042, system clocks per output sample (50 MHz / 1042 ≈ 48 kHz); must be ≥ 3.
- SAMPLE_HZ, 48000, nominal sample rate used as accumulator modulus; must be ≤ 2^17-1.
- AMP, 8192, per-voice square amplitude (positive LSBs); must be in 1..16383.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- en  in  1  run enable; low freezes all state.
- freq1  in  11  voice 1 frequency in Hz; 0 = silent.
- freq2  in  11  voice 2 frequency in Hz; 0 = silent.
- sample  out  16  signed two's-complement mixed sample.
- sample_valid  out  1  one-cycle strobe; sample is new this cycle.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Prescaler = 0; both voice accumulators = 0; polarity = positive; active = 0.
  - sample = 0; sample_valid = 0; the pipeline flag is cleared.
  - Reset overrides en and any in-flight tick.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1, then wraps to 0.
  - The tick cycle is the cycle in which prescaler == TICK_DIV-1 and en=1.
  - en=0: prescaler holds, no ticks occur, sample holds its value, sample_valid = 0.
- Voice update at the end of a tick cycle (independent per voice, f = freqN sampled that cycle, acc is 17 bits):
  - If f == 0 or 2f ≥ SAMPLE_HZ: acc ← 0, polarity ← positive, active ← 0.
  - Else: active ← 1; s = acc + 2f.
    - If s ≥ SAMPLE_HZ: acc ← s - SAMPLE_HZ and polarity toggles.
    - Else: acc ← s.
  - Net effect: exactly f full cycles per SAMPLE_HZ ticks.
- Level per voice: active ? (positive ? +AMP : -AMP) : 0.
- Mix stage (cycle after the tick cycle):
  - sample ← level1 + level2, computed in 16-bit signed; no overflow is possible given the AMP bound.
  - The pipeline flag is registered so that sample and sample_valid change at the end of that cycle.
  - sample_valid = 1 for exactly one cycle, the second cycle after the tick cycle (latency 2 from the freq sampling edge).
- en drop between tick and mix: if en falls the cycle after a tick, the pending mix still completes and sample_valid still pulses once.
- sample_valid period is exactly TICK_DIV cycles while en stays high.
- Frequency change: a new nonzero f continues from the current acc and polarity, so the phase is continuous, with no reset of the accumulator.
  - Change to 0: the voice contributes 0 from the next sample. Its next start begins with polarity positive and acc = 0.
- Input frequencies are sampled only on tick cycles; changes between ticks are ignored until the next tick.

Test Plan:
- Reset with TICK_DIV=4, en=1, both freqs 0 → sample=0, sample_valid pulses every 4 cycles, first pulse 2 cycles after the first tick.
- Hold: freq2=440, freq1=0, SAMPLE_HZ=48000 →
  - first 54 valid samples = +8192, the 55th = -8192 (880·55 ≥ 48000);
  - over 48000 valid samples, exactly 880 sign changes.
- Same frequency: freq1=freq2=1000 → samples alternate only between +16384 and -16384 (never 0 once active); 2000 toggles per 48000 samples.
- Stop and restart: freq2 changes 440→0 mid-tone → the next valid sample is 0. Then freq2=440 again → the first sample is +8192, and the accumulator restarts from 0 (first toggle again at sample 55).
- Enable gating: deassert en for 100 cycles → no sample_valid, sample and prescaler frozen; reasserting resumes with the prescaler at its held value.
  - Dropping en on the cycle after a tick still yields that one pulse.
- Boundary: SAMPLE_HZ=4000, freq1=2000 (2f = SAMPLE_HZ) → voice 1 silent (0). Pull reset low mid-tone → next cycle sample=0, sample_valid=0, and the tone restarts positive after release.
